// File: rtl/hash_req_responder.sv
// hash_req_responder: turns a one- or two-block hash request into block issues on a plain sha256 core
// and returns the final digest with a one-cycle done pulse.
module hash_req_responder #(
  parameter int BLOCK_W  = 512,
  parameter int DIGEST_W = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hash_start,
  input  logic [2*BLOCK_W-1:0]   hash_data_in,
  input  logic                   message_length,
  input  logic                   continue_intermediate,
  output logic [DIGEST_W-1:0]    hash_data_out,
  output logic                   hash_done,
  output logic                   busy,
  output logic                   sha256_start,
  output logic                   sha256_init_message,
  output logic [BLOCK_W-1:0]     sha256_data_in,
  output logic                   sha256_init_iv,
  input  logic [DIGEST_W-1:0]    sha256_data_out,
  input  logic                   sha256_data_out_valid,
  input  logic                   sha256_done,
  input  logic                   sha256_busy
);
  typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE} state_t;
  state_t                 state_q, state_d;
  logic [2*BLOCK_W-1:0]   data_q, data_d;
  logic                   len_q, len_d;
  logic                   cont_q, cont_d;
  logic [DIGEST_W-1:0]    digest_q, digest_d;
  logic                   issue;
  logic                   unused_valid;
  assign unused_valid = sha256_data_out_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      data_q   <= '0;
      len_q    <= 1'b0;
      cont_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      cont_q   <= cont_d;
      digest_q <= digest_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    cont_d   = cont_q;
    digest_d = digest_q;
    issue    = (state_q == ISSUE1 || state_q == ISSUE2) && !sha256_busy;
    case (state_q)
      IDLE: if (hash_start) begin
        state_d = ISSUE1;
        data_d  = hash_data_in;
        len_d   = message_length;
        cont_d  = continue_intermediate;
      end
      ISSUE1: state_d = issue ? WAIT1 : ISSUE1;
      WAIT1: if (sha256_done) begin
        state_d  = len_q ? ISSUE2 : DONE;
        digest_d = len_q ? digest_q : sha256_data_out;
      end
      ISSUE2: state_d = issue ? WAIT2 : ISSUE2;
      WAIT2: if (sha256_done) begin
        state_d  = DONE;
        digest_d = sha256_data_out;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign hash_data_out       = digest_q;
  assign hash_done           = state_q == DONE;
  assign busy                = state_q != IDLE;
  assign sha256_start        = issue;
  assign sha256_init_message = issue;
  assign sha256_init_iv      = state_q == ISSUE1 && !cont_q;
  // the block stays on the bus for the whole issue/wait span so the core may sample it late
  assign sha256_data_in      = (state_q == ISSUE1 || state_q == WAIT1) ? data_q[2*BLOCK_W-1:BLOCK_W] :
                               (state_q == ISSUE2 || state_q == WAIT2) ? data_q[BLOCK_W-1:0] : '0;
endmodule
